// File: rtl/dcache_miss_unit_pkg.sv
// Shared definitions for the data-cache miss handler: one-hot state
// encodings, AXI bridge request type codes and line geometry.
package dcache_miss_unit_pkg;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_WB_REQ  = 5'b00010,
        ST_RD_REQ  = 5'b00100,
        ST_RD_WAIT = 5'b01000,
        ST_DONE    = 5'b10000
    } state_t;

    localparam logic [2:0] LINE_TYPE = 3'b100;
    localparam logic [2:0] WORD_TYPE = 3'b010;
    localparam logic [3:0] FULL_STRB = 4'hf;
    localparam int         OFFSET_W  = 4;

endpackage

// File: rtl/dcache_miss_unit.sv
// Data-cache miss handler: optionally writes back a dirty victim line,
// refills the missing line as a 4-beat burst, assembles the returned words
// and hands the finished line back to the dcache.
module dcache_miss_unit
    import dcache_miss_unit_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      miss_req,
    input  logic [ADDR_W-1:0]         miss_addr,
    input  logic                      miss_dirty,
    input  logic [ADDR_W-1:0]         victim_addr,
    input  logic [127:0]              victim_data,
    output logic                      miss_ready,
    output logic                      refill_valid,
    input  logic                      refill_ready,
    output logic [ADDR_W-1:0]         refill_addr,
    output logic [127:0]              refill_data,
    output logic                      rd_req,
    output logic [2:0]                rd_type,
    output logic [ADDR_W-1:0]         rd_addr,
    input  logic                      rd_rdy,
    input  logic                      ret_valid,
    input  logic                      ret_last,
    input  logic [31:0]               ret_data,
    output logic                      wr_req,
    output logic [2:0]                wr_type,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [3:0]                wr_wstrb,
    output logic [127:0]              wr_data,
    input  logic                      wr_rdy
);

    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << OFFSET_W) - 1);

    state_t                      state;
    logic [ADDR_W-1:0]           miss_addr_q;
    logic [ADDR_W-1:0]           victim_addr_q;
    logic [127:0]                victim_data_q;
    logic [32*LINE_WORDS-1:0]    line_q;
    logic [1:0]                  cnt;

    // Miss FSM with registered handshake outputs; beats are also taken in
    // RD_REQ in case the bridge returns data before the address pulse.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state         <= ST_IDLE;
            miss_ready    <= 1'b1;
            rd_req        <= 1'b0;
            wr_req        <= 1'b0;
            refill_valid  <= 1'b0;
            miss_addr_q   <= '0;
            victim_addr_q <= '0;
            victim_data_q <= '0;
            line_q        <= '0;
            cnt           <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (miss_req) begin
                        miss_addr_q   <= miss_addr & ~OFFSET_MASK;
                        victim_addr_q <= victim_addr & ~OFFSET_MASK;
                        victim_data_q <= victim_data;
                        line_q        <= '0;
                        cnt           <= '0;
                        miss_ready    <= 1'b0;
                        if (miss_dirty) begin
                            state  <= ST_WB_REQ;
                            wr_req <= 1'b1;
                        end else begin
                            state  <= ST_RD_REQ;
                            rd_req <= 1'b1;
                        end
                    end
                end
                ST_WB_REQ: begin
                    if (wr_rdy) begin
                        wr_req <= 1'b0;
                        rd_req <= 1'b1;
                        state  <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ, ST_RD_WAIT: begin
                    if (state == ST_RD_REQ && rd_rdy) begin
                        rd_req <= 1'b0;
                        state  <= ST_RD_WAIT;
                    end
                    if (ret_valid) begin
                        line_q[{cnt, 5'b0} +: 32] <= ret_data;
                        cnt                       <= cnt + 2'd1;
                        if (ret_last) begin
                            rd_req       <= 1'b0;
                            refill_valid <= 1'b1;
                            state        <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (refill_ready) begin
                        refill_valid <= 1'b0;
                        miss_ready   <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: begin
                    state        <= ST_IDLE;
                    miss_ready   <= 1'b1;
                    rd_req       <= 1'b0;
                    wr_req       <= 1'b0;
                    refill_valid <= 1'b0;
                end
            endcase
        end
    end

    assign rd_type     = LINE_TYPE;
    assign wr_type     = LINE_TYPE;
    assign wr_wstrb    = FULL_STRB;
    assign rd_addr     = miss_addr_q;
    assign refill_addr = miss_addr_q;
    assign wr_addr     = victim_addr_q;
    assign wr_data     = victim_data_q;
    assign refill_data = line_q;

endmodule
